// File: rtl/period_counter.sv
// Free-running modulo counter that wraps after clear_period_i and emits a
// registered one-cycle ready_o strobe whenever an enabled step lands on interrupt_num_i.
module period_counter #(
  parameter int WIDTH_CNT = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic [WIDTH_CNT-1:0] clear_period_i,
  input  logic [WIDTH_CNT-1:0] interrupt_num_i,
  output logic                 ready_o
);

  logic [WIDTH_CNT-1:0] r_cnt;
  logic [WIDTH_CNT-1:0] w_cnt_next;
  logic                 w_match;
  logic                 r_ready;

  // Next count: >= compare so a lowered terminal count wraps instead of running past it.
  always_comb begin
    w_cnt_next = r_cnt;
    if (en_i) begin
      if (r_cnt >= clear_period_i) begin
        w_cnt_next = {WIDTH_CNT{1'b0}};
      end else begin
        w_cnt_next = r_cnt + WIDTH_CNT'(1);
      end
    end else begin
      w_cnt_next = r_cnt;
    end
  end

  // Match is taken on the value being landed, so the strobe lines up with cnt.
  always_comb begin
    w_match = 1'b0;
    if (en_i && (w_cnt_next == interrupt_num_i)) begin
      w_match = 1'b1;
    end else begin
      w_match = 1'b0;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {WIDTH_CNT{1'b0}};
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  // Strobe register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= w_match;
    end
  end

  assign ready_o = r_ready;

endmodule

// File: tb/tb_period_counter.sv
// Directed self-checking bench for period_counter; expected strobe positions
// are hand-derived edge numbers counted from a cleared counter.
module tb_period_counter;

  logic       clk;
  logic       rst_n;
  logic       en_i;
  logic [4:0] clear_period_i;
  logic [4:0] interrupt_num_i;
  logic       ready_o;

  int total;
  int bad;

  period_counter #(.WIDTH_CNT(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_i            (en_i),
    .clear_period_i  (clear_period_i),
    .interrupt_num_i (interrupt_num_i),
    .ready_o         (ready_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges; leaves counter at 0 with enable low.
  task automatic apply_reset;
    en_i  = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    en_i = 1'b0;
    clear_period_i = 5'd3;
    interrupt_num_i = 5'd0;
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if (ready_o !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold edge=%0d got=%b want=0", k, ready_o);
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (ready_o !== 1'b0) begin
        bad++;
        $display("FAIL idle_after_reset edge=%0d got=%b want=0", k, ready_o);
      end
    end
  endtask

  task automatic test_basic;
    logic exp;
    apply_reset();
    clear_period_i = 5'd31;
    interrupt_num_i = 5'd2;
    en_i = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      tick();
      exp = (k == 2 || k == 34 || k == 66);
      total++;
      if (ready_o !== exp) begin
        bad++;
        $display("FAIL basic_cp31_in2 edge=%0d got=%b want=%b", k, ready_o, exp);
      end
    end
  endtask

  task automatic test_wrap_zero;
    logic exp;
    apply_reset();
    clear_period_i = 5'd3;
    interrupt_num_i = 5'd0;
    en_i = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp = (k == 4 || k == 8 || k == 12);
      total++;
      if (ready_o !== exp) begin
        bad++;
        $display("FAIL wrap_in0 edge=%0d got=%b want=%b", k, ready_o, exp);
      end
    end
  endtask

  task automatic test_no_match;
    apply_reset();
    clear_period_i = 5'd5;
    interrupt_num_i = 5'd10;
    en_i = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      total++;
      if (ready_o !== 1'b0) begin
        bad++;
        $display("FAIL no_match edge=%0d got=%b want=0", k, ready_o);
      end
    end
  endtask

  task automatic test_en_hold;
    apply_reset();
    clear_period_i = 5'd31;
    interrupt_num_i = 5'd2;
    en_i = 1'b1;
    tick();
    total++;
    if (ready_o !== 1'b0) begin
      bad++;
      $display("FAIL hold_first_step got=%b want=0", ready_o);
    end
    en_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (ready_o !== 1'b0) begin
        bad++;
        $display("FAIL hold_frozen edge=%0d got=%b want=0", k, ready_o);
      end
    end
    en_i = 1'b1;
    tick();
    total++;
    if (ready_o !== 1'b1) begin
      bad++;
      $display("FAIL hold_resume got=%b want=1", ready_o);
    end
    tick();
    total++;
    if (ready_o !== 1'b0) begin
      bad++;
      $display("FAIL hold_one_cycle got=%b want=0", ready_o);
    end
    en_i = 1'b0;
    tick();
    total++;
    if (ready_o !== 1'b0) begin
      bad++;
      $display("FAIL hold_disabled got=%b want=0", ready_o);
    end
  endtask

  task automatic test_async_reset;
    logic exp;
    apply_reset();
    clear_period_i = 5'd7;
    interrupt_num_i = 5'd3;
    en_i = 1'b1;
    tick();
    tick();
    tick();
    total++;
    if (ready_o !== 1'b1) begin
      bad++;
      $display("FAIL areset_pre got=%b want=1", ready_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (ready_o !== 1'b0) begin
      bad++;
      $display("FAIL areset_immediate got=%b want=0", ready_o);
    end
    tick();
    total++;
    if (ready_o !== 1'b0) begin
      bad++;
      $display("FAIL areset_held got=%b want=0", ready_o);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp = (k == 3);
      total++;
      if (ready_o !== exp) begin
        bad++;
        $display("FAIL areset_restart edge=%0d got=%b want=%b", k, ready_o, exp);
      end
    end
  endtask

  task automatic test_cp_zero;
    apply_reset();
    clear_period_i = 5'd0;
    interrupt_num_i = 5'd0;
    en_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      total++;
      if (ready_o !== 1'b1) begin
        bad++;
        $display("FAIL cp0_in0 edge=%0d got=%b want=1", k, ready_o);
      end
    end
    en_i = 1'b0;
    tick();
    total++;
    if (ready_o !== 1'b0) begin
      bad++;
      $display("FAIL cp0_disabled got=%b want=0", ready_o);
    end
    en_i = 1'b1;
    interrupt_num_i = 5'd1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++;
      if (ready_o !== 1'b0) begin
        bad++;
        $display("FAIL cp0_in1 edge=%0d got=%b want=0", k, ready_o);
      end
    end
  endtask

  task automatic test_lower_cp;
    logic exp;
    apply_reset();
    clear_period_i = 5'd31;
    interrupt_num_i = 5'd0;
    en_i = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      total++;
      if (ready_o !== 1'b0) begin
        bad++;
        $display("FAIL lower_cp_run edge=%0d got=%b want=0", k, ready_o);
      end
    end
    clear_period_i = 5'd4;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp = (k == 1 || k == 6);
      total++;
      if (ready_o !== exp) begin
        bad++;
        $display("FAIL lower_cp_wrap edge=%0d got=%b want=%b", k, ready_o, exp);
      end
    end
  endtask

  task automatic test_full_range;
    logic exp;
    apply_reset();
    clear_period_i = 5'd31;
    interrupt_num_i = 5'd31;
    en_i = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      tick();
      exp = (k == 31 || k == 63);
      total++;
      if (ready_o !== exp) begin
        bad++;
        $display("FAIL full_range edge=%0d got=%b want=%b", k, ready_o, exp);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    en_i = 1'b0;
    clear_period_i = 5'd0;
    interrupt_num_i = 5'd0;
    test_reset();
    test_basic();
    test_wrap_zero();
    test_no_match();
    test_en_hold();
    test_async_reset();
    test_cp_zero();
    test_lower_cp();
    test_full_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
